line_fill_buffer: RTL and testbench

//  Refill stage directly upstream of the instruction-cache data array.
//  - On a miss, requests one 320-bit block from the memory side and collects it as BEAT_WIDTH-bit response beats.
//  - Issues a single masked row write into the data array's write port.
//  - Holds that write while the array is halted, because the array's clock is gated by i_halt.

---
 rtl/line_fill_buffer.sv | 158 +++++++++++++++
 tb/tb_line_fill_buffer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_buffer.sv
// Refill stage for the I-cache data array: fetches one block as memory beats and issues one masked row write.
// Defining LFB_RSP_ERR_EN adds response-error handling, which drops the fill instead of writing it.
module line_fill_buffer #(
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_BLOCKS  = 4,
    parameter int BLOCK_WIDTH = 320,
    parameter int BEAT_WIDTH  = 64,
    parameter int BLK_W       = $clog2(NUM_BLOCKS),
    parameter int ROW_WIDTH   = NUM_BLOCKS * BLOCK_WIDTH
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        i_halt,
    input  logic                        i_miss_valid,
    input  logic [ADDR_WIDTH-1:0]       i_miss_addr,
    input  logic [BLK_W-1:0]            i_miss_block,
    output logic                        o_miss_ready,
    output logic                        o_mem_req_valid,
    output logic [ADDR_WIDTH+BLK_W-1:0] o_mem_req_addr,
    input  logic                        i_mem_req_ready,
    input  logic                        i_mem_rsp_valid,
    input  logic [BEAT_WIDTH-1:0]       i_mem_rsp_data,
    output logic                        o_mem_rsp_ready,
`ifdef LFB_RSP_ERR_EN
    input  logic                        i_mem_rsp_err,
    output logic                        o_fill_err,
`endif
    output logic                        o_w_valid,
    output logic [ADDR_WIDTH-1:0]       o_w_addr,
    output logic [ROW_WIDTH-1:0]        o_w_data,
    output logic [NUM_BLOCKS-1:0]       o_w_wmask,
    output logic                        o_fill_done
);

    localparam int BEATS = BLOCK_WIDTH / BEAT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_WRITE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BLK_W-1:0]        blk_q, blk_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [BLOCK_WIDTH-1:0]  line_q, line_d;
`ifdef LFB_RSP_ERR_EN
    logic                    err_q, err_d;
    logic                    fill_err_q, fill_err_d;

    assign o_fill_err = fill_err_q;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            blk_q      <= '0;
            cnt_q      <= '0;
            line_q     <= '0;
`ifdef LFB_RSP_ERR_EN
            err_q      <= 1'b0;
            fill_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            blk_q      <= blk_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
`ifdef LFB_RSP_ERR_EN
            err_q      <= err_d;
            fill_err_q <= fill_err_d;
`endif
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        blk_d           = blk_q;
        cnt_d           = cnt_q;
        line_d          = line_q;
`ifdef LFB_RSP_ERR_EN
        err_d           = err_q;
        fill_err_d      = 1'b0;
`endif
        o_miss_ready    = 1'b0;
        o_mem_req_valid = 1'b0;
        o_mem_req_addr  = '0;
        o_mem_rsp_ready = 1'b0;
        o_w_valid       = 1'b0;
        o_w_addr        = '0;
        o_w_data        = '0;
        o_w_wmask       = '0;
        o_fill_done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_miss_ready = 1'b1;
                if (i_miss_valid) begin
                    addr_d  = i_miss_addr;
                    blk_d   = i_miss_block;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                o_mem_req_valid = 1'b1;
                o_mem_req_addr  = {addr_q, blk_q};
                if (i_mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                o_mem_rsp_ready = 1'b1;
                if (i_mem_rsp_valid) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (cnt_q == 3'(b)) line_d[b*BEAT_WIDTH +: BEAT_WIDTH] = i_mem_rsp_data;
                    end
                    cnt_d = cnt_q + 3'd1;
`ifdef LFB_RSP_ERR_EN
                    err_d = err_q | i_mem_rsp_err;
`endif
                    if (cnt_q == 3'(BEATS - 1)) begin
`ifdef LFB_RSP_ERR_EN
                        // A poisoned block is dropped; the requester sees o_fill_err and may retry.
                        if (err_q | i_mem_rsp_err) begin
                            err_d      = 1'b0;
                            fill_err_d = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            state_d    = S_WRITE;
                        end
`else
                        state_d = S_WRITE;
`endif
                    end
                end
            end
            S_WRITE: begin
                // The array clock is gated while halted, so the write is only taken once i_halt drops.
                o_w_valid = 1'b1;
                o_w_addr  = addr_q;
                o_w_data  = {NUM_BLOCKS{line_q}};
                o_w_wmask = NUM_BLOCKS'(1) << blk_q;
                if (!i_halt) begin
                    o_fill_done = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed self-checking bench for line_fill_buffer; the error scenario runs only when LFB_RSP_ERR_EN is defined.
module tb_line_fill_buffer;

    logic          clk;
    logic          arst;
    logic          i_halt;
    logic          i_miss_valid;
    logic [3:0]    i_miss_addr;
    logic [1:0]    i_miss_block;
    logic          o_miss_ready;
    logic          o_mem_req_valid;
    logic [5:0]    o_mem_req_addr;
    logic          i_mem_req_ready;
    logic          i_mem_rsp_valid;
    logic [63:0]   i_mem_rsp_data;
    logic          o_mem_rsp_ready;
    logic          i_mem_rsp_err;
    logic          o_fill_err;
    logic          o_w_valid;
    logic [3:0]    o_w_addr;
    logic [1279:0] o_w_data;
    logic [3:0]    o_w_wmask;
    logic          o_fill_done;

    int checks;
    int failures;

    line_fill_buffer dut (
        .clk             (clk),
        .arst            (arst),
        .i_halt          (i_halt),
        .i_miss_valid    (i_miss_valid),
        .i_miss_addr     (i_miss_addr),
        .i_miss_block    (i_miss_block),
        .o_miss_ready    (o_miss_ready),
        .o_mem_req_valid (o_mem_req_valid),
        .o_mem_req_addr  (o_mem_req_addr),
        .i_mem_req_ready (i_mem_req_ready),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .i_mem_rsp_data  (i_mem_rsp_data),
        .o_mem_rsp_ready (o_mem_rsp_ready),
`ifdef LFB_RSP_ERR_EN
        .i_mem_rsp_err   (i_mem_rsp_err),
        .o_fill_err      (o_fill_err),
`endif
        .o_w_valid       (o_w_valid),
        .o_w_addr        (o_w_addr),
        .o_w_data        (o_w_data),
        .o_w_wmask       (o_w_wmask),
        .o_fill_done     (o_fill_done)
    );

`ifndef LFB_RSP_ERR_EN
    assign o_fill_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] beat_val(input logic [7:0] tag, input int i);
        return {tag, 56'(i)};
    endfunction

    function automatic logic [319:0] blk_val(input logic [7:0] tag);
        logic [319:0] r;
        for (int i = 0; i < 5; i++) r[i*64 +: 64] = beat_val(tag, i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_halt          = 1'b0;
        i_miss_valid    = 1'b0;
        i_miss_addr     = '0;
        i_miss_block    = '0;
        i_mem_req_ready = 1'b1;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data  = '0;
        i_mem_rsp_err   = 1'b0;
    endtask

    // Drives one complete fill with no stalls; reports the cycle (miss = 0) and contents of the write, or wc = -1.
    task automatic run_fill(input logic [3:0] a, input logic [1:0] b, input logic [7:0] tag,
                            output logic [1279:0] wd, output logic [3:0] wm, output logic [3:0] wa,
                            output int wc);
        int beat;
        beat = 0; wc = -1; wd = '0; wm = '0; wa = '0;
        tick();
        i_miss_valid = 1'b1; i_miss_addr = a; i_miss_block = b; i_mem_req_ready = 1'b1; i_mem_rsp_valid = 1'b0;
        for (int c = 0; c < 30 && wc < 0; c++) begin
            if (c > 0) begin
                tick();
                i_miss_valid    = 1'b0;
                i_mem_rsp_valid = (beat < 5);
                i_mem_rsp_data  = beat_val(tag, beat);
            end
            sample();
            if (o_mem_rsp_ready && i_mem_rsp_valid) beat++;
            if (o_w_valid) begin wc = c; wd = o_w_data; wm = o_w_wmask; wa = o_w_addr; end
        end
        tick();
        i_mem_rsp_valid = 1'b0;
        i_miss_valid    = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        idle_inputs();
        sample(); sample();
        checks++; if (o_miss_ready !== 1'b1) begin failures++; $display("FAIL reset_miss_ready got=%0b exp=1", o_miss_ready); end
        checks++; if ({o_mem_req_valid, o_mem_rsp_ready, o_w_valid, o_fill_done} !== 4'b0000) begin failures++;
            $display("FAIL reset_strobes got=%b exp=0000", {o_mem_req_valid, o_mem_rsp_ready, o_w_valid, o_fill_done}); end
        checks++; if ({o_mem_req_addr, o_w_addr, o_w_wmask} !== 14'h0) begin failures++;
            $display("FAIL reset_addr_mask got=%h exp=0", {o_mem_req_addr, o_w_addr, o_w_wmask}); end
        checks++; if (o_w_data !== '0) begin failures++; $display("FAIL reset_w_data got=%h exp=0", o_w_data); end
        @(posedge clk); #1;
        arst = 1'b0;
    endtask

    task automatic test_basic();
        logic [319:0] exp_blk;
        exp_blk = blk_val(8'h11);
        tick(); i_miss_valid = 1'b1; i_miss_addr = 4'd5; i_miss_block = 2'd2; i_mem_req_ready = 1'b1;
        sample();
        checks++; if (o_miss_ready !== 1'b1) begin failures++; $display("FAIL basic_miss_ready got=%0b exp=1", o_miss_ready); end
        tick(); i_miss_valid = 1'b0;
        sample();
        checks++; if ({o_mem_req_valid, o_mem_req_addr} !== {1'b1, 6'h16}) begin failures++;
            $display("FAIL basic_req got=%0b/%h exp=1/16", o_mem_req_valid, o_mem_req_addr); end
        for (int i = 0; i < 5; i++) begin
            tick(); i_mem_rsp_valid = 1'b1; i_mem_rsp_data = beat_val(8'h11, i);
            sample();
            checks++; if ({o_mem_rsp_ready, o_w_valid} !== 2'b10) begin failures++;
                $display("FAIL basic_beat%0d rsp_ready/w_valid got=%b exp=10", i, {o_mem_rsp_ready, o_w_valid}); end
        end
        tick(); i_mem_rsp_valid = 1'b0;
        sample();
        checks++; if ({o_w_valid, o_fill_done} !== 2'b11) begin failures++;
            $display("FAIL basic_write_cycle7 valid/done got=%b exp=11", {o_w_valid, o_fill_done}); end
        checks++; if ({o_w_addr, o_w_wmask} !== {4'd5, 4'b0100}) begin failures++;
            $display("FAIL basic_addr_mask got=%h/%b exp=5/0100", o_w_addr, o_w_wmask); end
        checks++; if (o_w_data[959:640] !== exp_blk) begin failures++;
            $display("FAIL basic_lane2 got=%h exp=%h", o_w_data[959:640], exp_blk); end
        checks++; if (o_w_data !== {4{exp_blk}}) begin failures++;
            $display("FAIL basic_replicated got=%h exp_lane=%h", o_w_data, exp_blk); end
        tick();
        sample();
        checks++; if ({o_miss_ready, o_w_valid, o_fill_done} !== 3'b100) begin failures++;
            $display("FAIL basic_after_write got=%b exp=100", {o_miss_ready, o_w_valid, o_fill_done}); end
    endtask

    task automatic test_stall();
        logic [319:0] exp_blk;
        exp_blk = blk_val(8'h11);
        tick(); i_miss_valid = 1'b1; i_miss_addr = 4'd5; i_miss_block = 2'd2; i_mem_req_ready = 1'b0;
        sample();
        for (int c = 0; c < 4; c++) begin
            tick(); i_miss_valid = 1'b0; i_mem_req_ready = (c == 3);
            sample();
            checks++; if ({o_mem_req_valid, o_mem_req_addr} !== {1'b1, 6'h16}) begin failures++;
                $display("FAIL stall_req_hold%0d got=%0b/%h exp=1/16", c, o_mem_req_valid, o_mem_req_addr); end
        end
        for (int i = 0; i < 5; i++) begin
            tick(); i_mem_rsp_valid = 1'b0; i_mem_rsp_data = 64'hFFFF_FFFF_FFFF_FFFF;
            sample();
            checks++; if ({o_mem_rsp_ready, o_w_valid} !== 2'b10) begin failures++;
                $display("FAIL stall_gap%0d got=%b exp=10", i, {o_mem_rsp_ready, o_w_valid}); end
            tick(); i_mem_rsp_valid = 1'b1; i_mem_rsp_data = beat_val(8'h11, i);
            sample();
        end
        tick(); i_mem_rsp_valid = 1'b0;
        sample();
        checks++; if ({o_w_valid, o_fill_done, o_w_wmask} !== {2'b11, 4'b0100}) begin failures++;
            $display("FAIL stall_write got=%b exp=110100", {o_w_valid, o_fill_done, o_w_wmask}); end
        checks++; if (o_w_data !== {4{exp_blk}}) begin failures++;
            $display("FAIL stall_data got=%h exp_lane=%h", o_w_data, exp_blk); end
        tick(); i_mem_req_ready = 1'b1;
    endtask

    task automatic test_halt();
        logic [319:0] exp_blk;
        int dones;
        exp_blk = blk_val(8'h22);
        dones = 0;
        tick(); i_halt = 1'b1; i_miss_valid = 1'b1; i_miss_addr = 4'hA; i_miss_block = 2'd0; i_mem_req_ready = 1'b1;
        sample();
        tick(); i_miss_valid = 1'b0;
        sample();
        checks++; if (o_mem_req_valid !== 1'b1) begin failures++; $display("FAIL halt_req_proceeds got=%0b exp=1", o_mem_req_valid); end
        for (int i = 0; i < 5; i++) begin
            tick(); i_mem_rsp_valid = 1'b1; i_mem_rsp_data = beat_val(8'h22, i);
            sample();
            checks++; if (o_mem_rsp_ready !== 1'b1) begin failures++; $display("FAIL halt_beat%0d rsp_ready got=%0b exp=1", i, o_mem_rsp_ready); end
        end
        for (int c = 0; c < 5; c++) begin
            tick(); i_mem_rsp_valid = 1'b0; i_halt = (c < 4);
            sample();
            if (o_fill_done) dones++;
            checks++; if ({o_w_valid, o_w_addr, o_w_wmask} !== {1'b1, 4'hA, 4'b0001} || o_w_data !== {4{exp_blk}}) begin failures++;
                $display("FAIL halt_hold%0d valid/addr/mask got=%0b/%h/%b exp=1/a/0001", c, o_w_valid, o_w_addr, o_w_wmask); end
            checks++; if (o_fill_done !== (c == 4)) begin failures++;
                $display("FAIL halt_done%0d got=%0b exp=%0b", c, o_fill_done, (c == 4)); end
        end
        tick();
        sample();
        checks++; if ({o_w_valid, o_miss_ready, dones} !== {2'b01, 32'd1}) begin failures++;
            $display("FAIL halt_release w_valid/miss_ready/dones got=%0b/%0b/%0d exp=0/1/1", o_w_valid, o_miss_ready, dones); end
    endtask

    task automatic test_busy();
        tick(); i_miss_valid = 1'b1; i_miss_addr = 4'd3; i_miss_block = 2'd1; i_mem_req_ready = 1'b0;
        sample();
        checks++; if (o_miss_ready !== 1'b1) begin failures++; $display("FAIL busy_first_accept got=%0b exp=1", o_miss_ready); end
        for (int c = 0; c < 2; c++) begin
            tick(); i_miss_addr = 4'd9; i_miss_block = 2'd3; i_mem_rsp_valid = 1'b1;
            i_mem_rsp_data = 64'hBAD0_BAD0_BAD0_BAD0; i_mem_req_ready = (c == 1);
            sample();
            checks++; if ({o_miss_ready, o_mem_rsp_ready, o_mem_req_addr} !== {2'b00, 6'h0D}) begin failures++;
                $display("FAIL busy_req%0d miss/rsp_ready/addr got=%0b/%0b/%h exp=0/0/0d", c, o_miss_ready, o_mem_rsp_ready, o_mem_req_addr); end
        end
        for (int i = 0; i < 5; i++) begin
            tick(); i_mem_rsp_data = beat_val(8'h33, i);
            sample();
            checks++; if (o_miss_ready !== 1'b0) begin failures++; $display("FAIL busy_recv%0d miss_ready got=%0b exp=0", i, o_miss_ready); end
        end
        for (int c = 0; c < 3; c++) begin
            tick(); i_mem_rsp_data = 64'hBAD1_BAD1_BAD1_BAD1; i_halt = (c < 2);
            sample();
            checks++; if ({o_w_valid, o_miss_ready, o_mem_rsp_ready, o_fill_done} !== {3'b100, (c == 2)}) begin failures++;
                $display("FAIL busy_write%0d valid/miss/rsp/done got=%b exp=100%0b", c,
                         {o_w_valid, o_miss_ready, o_mem_rsp_ready, o_fill_done}, (c == 2)); end
        end
        checks++; if ({o_w_wmask, o_w_addr} !== {4'b0010, 4'd3} || o_w_data !== {4{blk_val(8'h33)}}) begin failures++;
            $display("FAIL busy_first_data mask/addr got=%b/%h exp=0010/3 lane0=%h", o_w_wmask, o_w_addr, o_w_data[319:0]); end
        tick(); i_mem_rsp_valid = 1'b0; i_halt = 1'b0; i_mem_req_ready = 1'b1;
        sample();
        checks++; if (o_miss_ready !== 1'b1) begin failures++; $display("FAIL busy_second_accept got=%0b exp=1", o_miss_ready); end
        tick(); i_miss_valid = 1'b0;
        sample();
        checks++; if ({o_mem_req_valid, o_mem_req_addr} !== {1'b1, 6'h27}) begin failures++;
            $display("FAIL busy_second_req got=%0b/%h exp=1/27", o_mem_req_valid, o_mem_req_addr); end
        for (int i = 0; i < 5; i++) begin
            tick(); i_mem_rsp_valid = 1'b1; i_mem_rsp_data = beat_val(8'h44, i);
            sample();
        end
        tick(); i_mem_rsp_valid = 1'b0;
        sample();
        checks++; if ({o_w_valid, o_w_wmask, o_w_addr} !== {1'b1, 4'b1000, 4'd9} || o_w_data !== {4{blk_val(8'h44)}}) begin failures++;
            $display("FAIL busy_second_write valid/mask/addr got=%0b/%b/%h exp=1/1000/9", o_w_valid, o_w_wmask, o_w_addr); end
        tick();
    endtask

    task automatic test_reset_midfill();
        logic [1279:0] wd;
        logic [3:0]    wm, wa;
        int            wc, seen;
        tick(); i_miss_valid = 1'b1; i_miss_addr = 4'd6; i_miss_block = 2'd3; i_mem_req_ready = 1'b1;
        tick(); i_miss_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); i_mem_rsp_valid = 1'b1; i_mem_rsp_data = beat_val(8'h55, i);
        end
        tick(); i_mem_rsp_valid = 1'b0;
        #2; arst = 1'b1;
        #1;
        checks++; if ({o_miss_ready, o_mem_rsp_ready, o_w_valid} !== 3'b100) begin failures++;
            $display("FAIL midreset_async got=%b exp=100", {o_miss_ready, o_mem_rsp_ready, o_w_valid}); end
        @(posedge clk); #1;
        arst = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick(); i_mem_rsp_valid = (c > 1); i_mem_rsp_data = beat_val(8'h55, 3);
            sample();
            if (o_w_valid) seen++;
        end
        i_mem_rsp_valid = 1'b0;
        checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_no_write got=%0d write cycles exp=0", seen); end
        run_fill(4'd6, 2'd3, 8'h66, wd, wm, wa, wc);
        checks++; if (wc !== 7) begin failures++; $display("FAIL midreset_refill_latency got=%0d exp=7", wc); end
        checks++; if ({wm, wa} !== {4'b1000, 4'd6} || wd !== {4{blk_val(8'h66)}}) begin failures++;
            $display("FAIL midreset_refill_data mask/addr got=%b/%h exp=1000/6 lane0=%h", wm, wa, wd[319:0]); end
    endtask

`ifdef LFB_RSP_ERR_EN
    task automatic test_rsp_err();
        logic [1279:0] wd;
        logic [3:0]    wm, wa;
        int            wc, seen;
        seen = 0;
        tick(); i_miss_valid = 1'b1; i_miss_addr = 4'd2; i_miss_block = 2'd0; i_mem_req_ready = 1'b1;
        tick(); i_miss_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); i_mem_rsp_valid = 1'b1; i_mem_rsp_data = beat_val(8'h77, i); i_mem_rsp_err = (i == 2);
            sample();
            if (o_w_valid) seen++;
            checks++; if ({o_mem_rsp_ready, o_fill_err} !== 2'b10) begin failures++;
                $display("FAIL err_beat%0d rsp_ready/fill_err got=%b exp=10", i, {o_mem_rsp_ready, o_fill_err}); end
        end
        tick(); i_mem_rsp_valid = 1'b0; i_mem_rsp_err = 1'b0;
        sample();
        checks++; if ({o_fill_err, o_miss_ready, o_w_valid, o_fill_done} !== 4'b1100) begin failures++;
            $display("FAIL err_pulse err/miss/valid/done got=%b exp=1100", {o_fill_err, o_miss_ready, o_w_valid, o_fill_done}); end
        for (int c = 0; c < 3; c++) begin
            tick();
            sample();
            if (o_w_valid) seen++;
            checks++; if (o_fill_err !== 1'b0) begin failures++; $display("FAIL err_pulse_len%0d got=%0b exp=0", c, o_fill_err); end
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL err_no_write got=%0d exp=0", seen); end
        run_fill(4'd2, 2'd1, 8'h88, wd, wm, wa, wc);
        checks++; if (wc !== 7 || wd !== {4{blk_val(8'h88)}} || wm !== 4'b0010) begin failures++;
            $display("FAIL err_cleared_refill latency/mask got=%0d/%b exp=7/0010", wc, wm); end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        arst     = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_stall();
        test_halt();
        test_busy();
        test_reset_midfill();
`ifdef LFB_RSP_ERR_EN
        test_rsp_err();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
